// File: rtl/paralelo_serial_param_if.sv
// -----------------------------------------------------------------------------
// paralelo_serial_param_if
//   Parallel-word handshake into the serialiser.
//   data_in   : WIDTH-bit payload word (producer -> serialiser)
//   valid_in  : data_in is valid this cycle (producer -> serialiser)
//   ready_out : serialiser buffer can take a word this cycle (serialiser -> producer)
//   master modport is the producer side; slave modport is the serialiser side.
// -----------------------------------------------------------------------------
interface paralelo_serial_param_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             ready_out;

   modport master (
      output data_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out
   );
endinterface

// File: rtl/paralelo_serial_param.sv
// -----------------------------------------------------------------------------
// paralelo_serial_param
//   Single-clock parallel-to-serial converter. Words arrive through a
//   valid/ready handshake into a 2-entry FIFO and leave one bit per clk_32f
//   cycle. After reset SYNC_WORDS copies of IDLE_WORD are sent as a preamble;
//   afterwards IDLE_WORD fills every word slot with no payload queued.
//
//   Ports
//     clk_32f      : bit clock, rising edge
//     reset        : asynchronous, active-high
//     in_if        : slave side of the word handshake (data_in/valid_in/ready_out)
//     data_out     : registered serial bit
//     word_start   : high while data_out carries the first bit of a word
//     sending_data : high for every bit of a payload word
//     sync_done    : high once the preamble has finished, until reset
//     error_out    : sticky, set when a word is offered while the FIFO is full
// -----------------------------------------------------------------------------
module paralelo_serial_param #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
   parameter bit               MSB_FIRST  = 1'b1,
   parameter int               SYNC_WORDS = 4
) (
   input  logic                    clk_32f,
   input  logic                    reset,
   paralelo_serial_param_if.slave  in_if,
   output logic                    data_out,
   output logic                    word_start,
   output logic                    sending_data,
   output logic                    sync_done,
   output logic                    error_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int SC_W  = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;

   typedef enum logic {
      ST_SYNC,
      ST_ACTIVE
   } state_t;

   state_t             state_q,      state_d;
   logic [SC_W-1:0]    sync_cnt_q,   sync_cnt_d;
   logic [CNT_W-1:0]   bitcnt_q,     bitcnt_d;
   logic [WIDTH-1:0]   shift_q,      shift_d;
   logic               data_out_q,   data_out_d;
   logic               word_start_q, word_start_d;
   logic               sending_q,    sending_d;
   logic               sync_done_q,  sync_done_d;
   logic               error_q,      error_d;

   logic [WIDTH-1:0]   mem_q [2];
   logic [WIDTH-1:0]   mem_d [2];
   logic               rd_ptr_q,     rd_ptr_d;
   logic               wr_ptr_q,     wr_ptr_d;
   logic [1:0]         count_q,      count_d;

   logic               full;
   logic               empty;
   logic               load;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   word;

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign load  = (bitcnt_q == CNT_W'(WIDTH - 1));

   // Held low during reset; otherwise only registered occupancy matters.
   assign in_if.ready_out = !full && !reset;

   assign data_out     = data_out_q;
   assign word_start   = word_start_q;
   assign sending_data = sending_q;
   assign sync_done    = sync_done_q;
   assign error_out    = error_q;

   always_comb begin
      state_d      = state_q;
      sync_cnt_d   = sync_cnt_q;
      bitcnt_d     = bitcnt_q + CNT_W'(1);
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      word_start_d = 1'b0;
      sending_d    = sending_q;
      sync_done_d  = sync_done_q;
      error_d      = error_q;
      mem_d        = mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      pop          = 1'b0;
      word         = IDLE_WORD;

      push = in_if.valid_in && !full;
      if (in_if.valid_in && full) begin
         error_d = 1'b1;
      end

      if (load) begin
         bitcnt_d     = '0;
         word_start_d = 1'b1;
         if ((state_q == ST_SYNC) && (sync_cnt_q != SC_W'(SYNC_WORDS))) begin
            sync_cnt_d = sync_cnt_q + SC_W'(1);
            sending_d  = 1'b0;
         end else begin
            // The load that ends the preamble already follows the active rule.
            if (state_q == ST_SYNC) begin
               state_d     = ST_ACTIVE;
               sync_done_d = 1'b1;
            end
            // Only registered FIFO contents are eligible: no same-edge bypass.
            if (!empty) begin
               pop       = 1'b1;
               word      = mem_q[rd_ptr_q];
               sending_d = 1'b1;
            end else begin
               sending_d = 1'b0;
            end
         end
         if (MSB_FIRST) begin
            data_out_d = word[WIDTH-1];
            shift_d    = word << 1;
         end else begin
            data_out_d = word[0];
            shift_d    = word >> 1;
         end
      end else begin
         if (MSB_FIRST) begin
            data_out_d = shift_q[WIDTH-1];
            shift_d    = shift_q << 1;
         end else begin
            data_out_d = shift_q[0];
            shift_d    = shift_q >> 1;
         end
      end

      if (push) begin
         mem_d[wr_ptr_q] = in_if.data_in;
         wr_ptr_d        = !wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = !rd_ptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SYNC;
         sync_cnt_q   <= '0;
         bitcnt_q     <= CNT_W'(WIDTH - 1);
         data_out_q   <= 1'b0;
         word_start_q <= 1'b0;
         sending_q    <= 1'b0;
         sync_done_q  <= 1'b0;
         error_q      <= 1'b0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         sync_cnt_q   <= sync_cnt_d;
         bitcnt_q     <= bitcnt_d;
         data_out_q   <= data_out_d;
         word_start_q <= word_start_d;
         sending_q    <= sending_d;
         sync_done_q  <= sync_done_d;
         error_q      <= error_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   // Payload storage needs no reset: occupancy and pointers define validity.
   always_ff @(posedge clk_32f) begin
      shift_q  <= shift_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
   end

endmodule

// File: tb/tb_paralelo_serial_param.sv
module tb_paralelo_serial_param;

   logic clk;
   logic rst1;
   logic rst2;

   logic dout1, ws1, snd1, sdone1, err1;
   logic dout2, ws2, snd2, sdone2, err2;

   int checks;
   int failures;

   paralelo_serial_param_if #(.WIDTH(8)) bus1 ();
   paralelo_serial_param_if #(.WIDTH(8)) bus2 ();

   paralelo_serial_param #(
      .WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .SYNC_WORDS(4)
   ) dut1 (
      .clk_32f(clk), .reset(rst1), .in_if(bus1),
      .data_out(dout1), .word_start(ws1), .sending_data(snd1),
      .sync_done(sdone1), .error_out(err1)
   );

   paralelo_serial_param #(
      .WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0), .SYNC_WORDS(0)
   ) dut2 (
      .clk_32f(clk), .reset(rst2), .in_if(bus2),
      .data_out(dout2), .word_start(ws2), .sending_data(snd2),
      .sync_done(sdone2), .error_out(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bit_of(input logic [7:0] w, input int k, input bit msb);
      return msb ? w[7-k] : w[k];
   endfunction

   task automatic test_reset();
      step();
      step();
      checks++; if (dout1 !== 1'b0) begin failures++; $display("FAIL reset_data_out got=%b exp=0", dout1); end
      checks++; if (ws1 !== 1'b0) begin failures++; $display("FAIL reset_word_start got=%b exp=0", ws1); end
      checks++; if (snd1 !== 1'b0) begin failures++; $display("FAIL reset_sending got=%b exp=0", snd1); end
      checks++; if (sdone1 !== 1'b0) begin failures++; $display("FAIL reset_sync_done got=%b exp=0", sdone1); end
      checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", err1); end
      checks++; if (bus1.ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus1.ready_out); end
      @(negedge clk);
      rst1 = 1'b0;
      #1;
      checks++; if (bus1.ready_out !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", bus1.ready_out); end
   endtask

   // Preamble of 4 BC words, then A5 pushed on edge 32 goes out at the 5th load.
   task automatic test_sync_payload();
      logic [7:0] w;
      for (int e = 1; e <= 48; e++) begin
         bus1.valid_in = (e == 32);
         bus1.data_in  = 8'hA5;
         step();
         w = (((e - 1) / 8) == 4) ? 8'hA5 : 8'hBC;
         checks++; if (dout1 !== bit_of(w, (e - 1) % 8, 1'b1)) begin failures++; $display("FAIL sync_bit edge=%0d got=%b exp=%b", e, dout1, bit_of(w, (e - 1) % 8, 1'b1)); end
         checks++; if (ws1 !== (((e - 1) % 8) == 0)) begin failures++; $display("FAIL sync_word_start edge=%0d got=%b", e, ws1); end
         checks++; if (snd1 !== (((e - 1) / 8) == 4)) begin failures++; $display("FAIL sync_sending edge=%0d got=%b", e, snd1); end
         checks++; if (sdone1 !== (e >= 33)) begin failures++; $display("FAIL sync_done edge=%0d got=%b exp=%b", e, sdone1, (e >= 33)); end
      end
      bus1.valid_in = 1'b0;
   endtask

   task automatic pulse_reset1();
      @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] w;
      int         wi;
      pulse_reset1();
      for (int e = 1; e <= 56; e++) begin
         bus1.valid_in = (e <= 3);
         bus1.data_in  = (e == 1) ? 8'h11 : ((e == 2) ? 8'h22 : 8'h33);
         step();
         if (e == 1) begin
            checks++; if (bus1.ready_out !== 1'b1) begin failures++; $display("FAIL ovf_ready_one got=%b exp=1", bus1.ready_out); end
         end
         if (e == 2) begin
            checks++; if (bus1.ready_out !== 1'b0) begin failures++; $display("FAIL ovf_ready_full got=%b exp=0", bus1.ready_out); end
         end
         if (e >= 3) begin
            checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL ovf_error edge=%0d got=%b exp=1", e, err1); end
         end else begin
            checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL ovf_error_early edge=%0d got=%b exp=0", e, err1); end
         end
         wi = (e - 1) / 8;
         w  = (wi == 4) ? 8'h11 : ((wi == 5) ? 8'h22 : 8'hBC);
         checks++; if (dout1 !== bit_of(w, (e - 1) % 8, 1'b1)) begin failures++; $display("FAIL ovf_bit edge=%0d got=%b exp=%b", e, dout1, bit_of(w, (e - 1) % 8, 1'b1)); end
         checks++; if (snd1 !== (wi == 4 || wi == 5)) begin failures++; $display("FAIL ovf_sending edge=%0d got=%b", e, snd1); end
      end
      bus1.valid_in = 1'b0;
      checks++; if (bus1.ready_out !== 1'b1) begin failures++; $display("FAIL ovf_ready_drained got=%b exp=1", bus1.ready_out); end
   endtask

   // Continues from test_overflow: edge 57 is a load edge in ACTIVE with empty FIFO.
   task automatic test_no_bypass();
      logic [7:0] w;
      int         wi;
      for (int e = 57; e <= 72; e++) begin
         bus1.valid_in = (e == 57);
         bus1.data_in  = 8'hC3;
         step();
         wi = (e - 1) / 8;
         w  = (wi == 8) ? 8'hC3 : 8'hBC;
         checks++; if (dout1 !== bit_of(w, (e - 1) % 8, 1'b1)) begin failures++; $display("FAIL bypass_bit edge=%0d got=%b exp=%b", e, dout1, bit_of(w, (e - 1) % 8, 1'b1)); end
         checks++; if (snd1 !== (wi == 8)) begin failures++; $display("FAIL bypass_sending edge=%0d got=%b", e, snd1); end
         checks++; if (ws1 !== (((e - 1) % 8) == 0)) begin failures++; $display("FAIL bypass_word_start edge=%0d got=%b", e, ws1); end
      end
      bus1.valid_in = 1'b0;
      checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", err1); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      checks++; if (bus2.ready_out !== 1'b1) begin failures++; $display("FAIL lsb_ready got=%b exp=1", bus2.ready_out); end
      for (int e = 1; e <= 16; e++) begin
         bus2.valid_in = (e == 1);
         bus2.data_in  = 8'hA5;
         step();
         w = (e >= 9) ? 8'hA5 : 8'hBC;
         checks++; if (dout2 !== bit_of(w, (e - 1) % 8, 1'b0)) begin failures++; $display("FAIL lsb_bit edge=%0d got=%b exp=%b", e, dout2, bit_of(w, (e - 1) % 8, 1'b0)); end
         checks++; if (snd2 !== (e >= 9)) begin failures++; $display("FAIL lsb_sending edge=%0d got=%b", e, snd2); end
         checks++; if (sdone2 !== 1'b1) begin failures++; $display("FAIL lsb_sync_done edge=%0d got=%b exp=1", e, sdone2); end
         checks++; if (ws2 !== (((e - 1) % 8) == 0)) begin failures++; $display("FAIL lsb_word_start edge=%0d got=%b", e, ws2); end
      end
      bus2.valid_in = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      pulse_reset1();
      for (int e = 1; e <= 36; e++) begin
         bus1.valid_in = (e == 31) || (e == 32);
         bus1.data_in  = (e == 31) ? 8'h5A : 8'h66;
         step();
      end
      bus1.valid_in = 1'b0;
      // Bit 3 of 5A (MSB first) is 1, with 66 still queued.
      checks++; if (dout1 !== 1'b1) begin failures++; $display("FAIL mid_bit3 got=%b exp=1", dout1); end
      checks++; if (snd1 !== 1'b1) begin failures++; $display("FAIL mid_sending got=%b exp=1", snd1); end
      #2;
      rst1 = 1'b1;
      #1;
      checks++; if (dout1 !== 1'b0) begin failures++; $display("FAIL mid_async_data_out got=%b exp=0", dout1); end
      checks++; if (snd1 !== 1'b0) begin failures++; $display("FAIL mid_async_sending got=%b exp=0", snd1); end
      checks++; if (bus1.ready_out !== 1'b0) begin failures++; $display("FAIL mid_async_ready got=%b exp=0", bus1.ready_out); end
      @(negedge clk);
      rst1 = 1'b0;
      for (int e = 1; e <= 48; e++) begin
         step();
         checks++; if (dout1 !== bit_of(8'hBC, (e - 1) % 8, 1'b1)) begin failures++; $display("FAIL mid_resync_bit edge=%0d got=%b exp=%b", e, dout1, bit_of(8'hBC, (e - 1) % 8, 1'b1)); end
         checks++; if (snd1 !== 1'b0) begin failures++; $display("FAIL mid_resync_sending edge=%0d got=%b exp=0", e, snd1); end
         checks++; if (sdone1 !== (e >= 33)) begin failures++; $display("FAIL mid_resync_sync_done edge=%0d got=%b", e, sdone1); end
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst1          = 1'b1;
      rst2          = 1'b1;
      bus1.valid_in = 1'b0;
      bus1.data_in  = 8'h00;
      bus2.valid_in = 1'b0;
      bus2.data_in  = 8'h00;

      test_reset();
      test_sync_payload();
      test_overflow();
      test_no_bypass();
      test_lsb_first();
      test_reset_mid_word();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
